// File: rtl/qspi_mem_arbiter.sv
// qspi_mem_arbiter
//   Shares one QSPI bus controller between the CPU instruction-fetch port
//   and the CPU data port. Each request is decoded into the flash or PSRAM
//   region and checked for alignment and permission. One transaction at a
//   time goes to the controller through a start/done handshake. The read
//   data and a one-cycle ready pulse then go back to the requester that won.
//
// Ports
//   clk, rst_n                          clock, synchronous active-low reset
//   i_req/i_addr                        ifetch request (always a word read)
//   i_rdata/i_ready/i_err               ifetch response
//   d_req/d_we/d_addr/d_wdata/d_size    data request
//   d_rdata/d_ready/d_err               data response
//   m_start/m_sel/m_addr/m_we/m_wdata/m_size  command to the QSPI controller
//   m_done/m_rdata                      completion from the QSPI controller
//   owner                               current/last grantee (0=ifetch, 1=data)
module qspi_mem_arbiter #(
   parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] FLASH_SIZE      = 32'h0100_0000,
   parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000,
   parameter logic [31:0] PSRAM_SIZE      = 32'h0080_0000,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        d_err,
   output logic        m_start,
   output logic        m_sel,
   output logic [23:0] m_addr,
   output logic        m_we,
   output logic [31:0] m_wdata,
   output logic [1:0]  m_size,
   input  logic        m_done,
   input  logic [31:0] m_rdata,
   output logic        owner
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t      state;
   logic [3:0]  starve_cnt;

   logic        grant_i;
   logic [31:0] g_addr;
   logic [1:0]  g_size;
   logic        g_we;
   logic [31:0] g_wdata;
   logic [31:0] flash_off;
   logic [31:0] psram_off;
   logic        in_flash;
   logic        in_psram;
   logic        g_err;

   // Arbitration and decode of whichever request would win this cycle.
   // Region membership uses the unsigned offset alone. An address below the
   // base wraps to a huge offset and fails the size compare.
   always_comb begin
      grant_i = i_req && (!d_req || (starve_cnt == STARVE_MAX));
      if (grant_i) begin
         g_addr  = i_addr;
         g_size  = 2'd2;
         g_we    = 1'b0;
         g_wdata = '0;
      end else begin
         g_addr  = d_addr;
         g_size  = d_size;
         g_we    = d_we;
         g_wdata = d_wdata;
      end
      flash_off = g_addr - FLASH_BASE_ADDR;
      psram_off = g_addr - PSRAM_BASE_ADDR;
      in_flash  = flash_off < FLASH_SIZE;
      in_psram  = psram_off < PSRAM_SIZE;
      g_err = (!in_flash && !in_psram)
            || (g_size == 2'd3)
            || ((g_size == 2'd1) && g_addr[0])
            || ((g_size == 2'd2) && (g_addr[1:0] != 2'b00))
            || (g_we && in_flash);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         starve_cnt <= '0;
         owner      <= 1'b0;
         i_rdata    <= '0;
         i_ready    <= 1'b0;
         i_err      <= 1'b0;
         d_rdata    <= '0;
         d_ready    <= 1'b0;
         d_err      <= 1'b0;
         m_start    <= 1'b0;
         m_sel      <= 1'b0;
         m_addr     <= '0;
         m_we       <= 1'b0;
         m_wdata    <= '0;
         m_size     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req || d_req) begin
                  owner <= ~grant_i;
                  if (grant_i)
                     starve_cnt <= '0;
                  else if (i_req)
                     starve_cnt <= starve_cnt + 4'd1;
                  if (g_err) begin
                     // The error response goes straight out. The controller is never started.
                     state <= S_ERR;
                     if (grant_i) begin
                        i_ready <= 1'b1;
                        i_err   <= 1'b1;
                     end else begin
                        d_ready <= 1'b1;
                        d_err   <= 1'b1;
                     end
                  end else begin
                     // The command registers double as the request latch.
                     // They hold until the next grant.
                     state   <= S_ISSUE;
                     m_start <= 1'b1;
                     m_sel   <= ~in_flash;
                     m_addr  <= in_flash ? flash_off[23:0] : psram_off[23:0];
                     m_we    <= g_we;
                     m_wdata <= g_wdata;
                     m_size  <= g_size;
                  end
               end
            end
            S_ISSUE: begin
               m_start <= 1'b0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (m_done) begin
                  state <= S_RESP;
                  if (owner) begin
                     d_ready <= 1'b1;
                     d_err   <= 1'b0;
                     if (!m_we)
                        d_rdata <= m_rdata;
                  end else begin
                     i_ready <= 1'b1;
                     i_err   <= 1'b0;
                     i_rdata <= m_rdata;
                  end
               end
            end
            S_RESP, S_ERR: begin
               i_ready <= 1'b0;
               i_err   <= 1'b0;
               d_ready <= 1'b0;
               d_err   <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
